// File: rtl/mem_port_arbiter_if.sv
// Bus bundle for mem_port_arbiter: two requester ports, the shared response and the memory drive.
// slave = arbiter side, master = requesters plus memory.
interface mem_port_arbiter_if #(
  parameter int word_size = 8,
  parameter int addr_size = 8
);
  logic                 req0;
  logic                 we0;
  logic [addr_size-1:0] addr0;
  logic [word_size-1:0] wdata0;
  logic                 req1;
  logic                 we1;
  logic [addr_size-1:0] addr1;
  logic [word_size-1:0] wdata1;
  logic                 gnt0;
  logic                 gnt1;
  logic                 ack0;
  logic                 ack1;
  logic [word_size-1:0] rdata;
  logic [addr_size-1:0] mem_addr;
  logic [word_size-1:0] mem_wdata;
  logic                 mem_we;
  logic [word_size-1:0] mem_rdata;

  modport slave (
    input  req0, we0, addr0, wdata0,
    input  req1, we1, addr1, wdata1,
    input  mem_rdata,
    output gnt0, gnt1, ack0, ack1, rdata,
    output mem_addr, mem_wdata, mem_we
  );

  modport master (
    output req0, we0, addr0, wdata0,
    output req1, we1, addr1, wdata1,
    output mem_rdata,
    input  gnt0, gnt1, ack0, ack1, rdata,
    input  mem_addr, mem_wdata, mem_we
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-port arbiter in front of a single-port synchronous memory; one access per 3 cycles.
// Optional macro ARB_ROUND_ROBIN_EN: round-robin on contention, otherwise port 0 has fixed priority.
module mem_port_arbiter #(
  parameter int word_size = 8,
  parameter int addr_size = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  mem_port_arbiter_if.slave      bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_next;

  logic                 r_gnt0;
  logic                 r_gnt1;
  logic                 r_ack0;
  logic                 r_ack1;
  logic                 r_wr;
  logic [word_size-1:0] r_rdata;
  logic [addr_size-1:0] r_mem_addr;
  logic [word_size-1:0] r_mem_wdata;
  logic                 r_mem_we;

  logic                 w_start;
  logic                 w_win1;

`ifdef ARB_ROUND_ROBIN_EN
  logic                 r_last;
  // On contention, serve the port that did not win last time.
  assign w_win1 = bus.req1 & (~bus.req0 | ~r_last);
`else
  assign w_win1 = bus.req1 & ~bus.req0;
`endif

  assign w_start = (r_state == IDLE) & (bus.req0 | bus.req1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_start) w_next = ACCESS;
      ACCESS:  w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // mem_we is dropped on leaving ACCESS so the memory sees exactly one write edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_gnt0      <= 1'b0;
      r_gnt1      <= 1'b0;
      r_ack0      <= 1'b0;
      r_ack1      <= 1'b0;
      r_wr        <= 1'b0;
      r_rdata     <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_we    <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      r_last      <= 1'b1;
`endif
    end else begin
      r_ack0 <= 1'b0;
      r_ack1 <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_mem_addr  <= w_win1 ? bus.addr1  : bus.addr0;
            r_mem_wdata <= w_win1 ? bus.wdata1 : bus.wdata0;
            r_mem_we    <= w_win1 ? bus.we1    : bus.we0;
            r_wr        <= w_win1 ? bus.we1    : bus.we0;
            r_gnt0      <= ~w_win1;
            r_gnt1      <= w_win1;
`ifdef ARB_ROUND_ROBIN_EN
            r_last      <= w_win1;
`endif
          end
        end
        ACCESS: begin
          r_mem_we <= 1'b0;
        end
        RESP: begin
          if (!r_wr) r_rdata <= bus.mem_rdata;
          r_ack0 <= r_gnt0;
          r_ack1 <= r_gnt1;
          r_gnt0 <= 1'b0;
          r_gnt1 <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.gnt0      = r_gnt0;
  assign bus.gnt1      = r_gnt1;
  assign bus.ack0      = r_ack0;
  assign bus.ack1      = r_ack1;
  assign bus.rdata     = r_rdata;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.mem_we    = r_mem_we;

endmodule
